modred_barrett: RTL and testbench

//  Pipelined Barrett modular reducer. Sits directly downstream of the Karatsuba

---
 rtl/modred_barrett.sv | 110 +++++++++++
 tb/tb_modred_barrett.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/modred_barrett.sv
// rtl/modred_barrett.sv - 3-stage pipelined Barrett reducer, c mod Q for c < Q^2, valid/ready handshake.
// Optional define MODRED_TAG_EN adds an in_tag/out_tag sideband that travels with each datum.
module modred_barrett #(
    parameter int               LOGQ      = 64,
    parameter logic [LOGQ-1:0]  Q         = 64'd18446744069414584321,
    parameter logic [LOGQ:0]    MU        = 65'h1_0000_0000_FFFF_FFFF,
    parameter int               DELAY_RED = 3,
    parameter int               TAG_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*LOGQ-1:0]   in_c,
`ifdef MODRED_TAG_EN
    input  logic [TAG_W-1:0]    in_tag,
    output logic [TAG_W-1:0]    out_tag,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LOGQ-1:0]     out_r
);

    localparam logic [LOGQ+1:0] Q_EXT  = {2'b00, Q};
    localparam logic [LOGQ+1:0] TWO_Q  = {1'b0, Q, 1'b0};

    if (DELAY_RED != 3) begin : g_bad_delay
        $error("modred_barrett: DELAY_RED must be 3");
    end

    logic stall;
    logic valid1_q, valid2_q, valid3_q;

    // Stage 1: quotient estimate. Only q2 >> (LOGQ+1) is ever read, so only that slice is held.
    logic [LOGQ:0]     c_hi;
    logic [2*LOGQ+1:0] q2_d;
    logic [LOGQ:0]     q2_hi_q;
    logic [LOGQ+1:0]   c1_q;

    // Stage 2: remainder modulo 2^(LOGQ+2); exact because the true value lies in [0, 3Q).
    logic [LOGQ+1:0]   q3q_d;
    logic [LOGQ+1:0]   r_d;
    logic [LOGQ+1:0]   r_q;

    // Stage 3: final conditional subtraction; the difference fits in LOGQ bits.
    logic [LOGQ-1:0]   out_r_d;
    logic [LOGQ-1:0]   out_r_q;

    assign stall     = valid3_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = valid3_q;
    assign out_r     = out_r_q;

    assign c_hi  = in_c[2*LOGQ-1:LOGQ-1];
    assign q2_d  = {{(LOGQ+1){1'b0}}, c_hi} * {{(LOGQ+1){1'b0}}, MU};
    assign q3q_d = {1'b0, q2_hi_q} * Q_EXT;
    assign r_d   = c1_q - q3q_d;

    always_comb begin
        out_r_d = r_q[LOGQ-1:0];
        if (r_q >= TWO_Q) begin
            out_r_d = r_q[LOGQ-1:0] - TWO_Q[LOGQ-1:0];
        end else if (r_q >= Q_EXT) begin
            out_r_d = r_q[LOGQ-1:0] - Q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            valid3_q <= 1'b0;
            q2_hi_q  <= '0;
            c1_q     <= '0;
            r_q      <= '0;
            out_r_q  <= '0;
        end else if (!stall) begin
            valid1_q <= in_valid;
            valid2_q <= valid1_q;
            valid3_q <= valid2_q;
            q2_hi_q  <= q2_d[2*LOGQ+1:LOGQ+1];
            c1_q     <= in_c[LOGQ+1:0];
            r_q      <= r_d;
            out_r_q  <= out_r_d;
        end
    end

`ifdef MODRED_TAG_EN
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

    assign out_tag = tag3_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else if (!stall) begin
            tag1_q <= in_tag;
            tag2_q <= tag1_q;
            tag3_q <= tag2_q;
        end
    end
`else
    if (TAG_W < 1) begin : g_bad_tag
        $error("modred_barrett: TAG_W must be positive");
    end
`endif

endmodule

// File: tb/tb_modred_barrett.sv
// tb/tb_modred_barrett.sv - randomized self-checking bench for modred_barrett against a % reference model.
module tb_modred_barrett;

    localparam logic [63:0]  Q     = 64'hFFFF_FFFF_0000_0001;
    localparam logic [127:0] Q_W   = {64'd0, Q};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_c = '0;
    logic         in_ready;
    logic         out_valid;
    logic [63:0]  out_r;
`ifdef MODRED_TAG_EN
    logic [7:0]   in_tag = '0;
    logic [7:0]   out_tag;
`endif

    modred_barrett dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
`ifdef MODRED_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_lat = 1'b0;
    logic [7:0]   tag_cnt = '0;
    logic [127:0] exp_q[$];
    int           cyc_q[$];
    logic [7:0]   tag_q[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_mod(input logic [127:0] c);
        return c % Q_W;
    endfunction

    function automatic logic [127:0] rand_res();
        logic [127:0] v;
        v = {64'd0, $urandom, $urandom};
        return v % Q_W;
    endfunction

    // One clock cycle: drive inputs after the falling edge, observe both handshakes, then advance.
    task automatic step(input bit iv, input logic [127:0] c, input logic [127:0] exp_v,
                        input bit ordy, output bit acc, output bit ov);
        logic [127:0] e;
        int           lat;
        logic [7:0]   t;
        in_valid  = iv;
        in_c      = c;
        out_ready = ordy;
`ifdef MODRED_TAG_EN
        in_tag    = tag_cnt;
`endif
        #1;
        acc = iv && in_ready;
        ov  = out_valid;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 128'd1, 128'd0);
            end else begin
                e   = exp_q.pop_front();
                lat = cyc_q.pop_front();
                t   = tag_q.pop_front();
                check_eq("out_r", {64'd0, out_r}, e);
                if (chk_lat) check_eq("latency", 128'(cyc - lat), 128'd3);
`ifdef MODRED_TAG_EN
                check_eq("out_tag", {120'd0, out_tag}, {120'd0, t});
`endif
            end
        end
        if (acc) begin
            exp_q.push_back(exp_v);
            cyc_q.push_back(cyc);
            tag_q.push_back(tag_cnt);
            tag_cnt = tag_cnt + 8'd1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string tag);
        bit acc, ov;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, '0, '0, 1'b1, acc, ov);
        check_eq(tag, 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        bit acc, ov, any_ov;
        int n_acc;
        logic [63:0]  snap_r;
        logic [127:0] a, b, p;
        bit pat [5];
        bit ov_log [12];

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check_eq("rst_out_r", {64'd0, out_r}, 128'd0);
        rst = 1'b1;
        #1;
        check_eq("rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);

        // Back-to-back small values with fixed latency
        chk_lat = 1'b1;
        step(1'b1, 128'd0,          128'd0, 1'b1, acc, ov); check_eq("t1_acc0", {127'd0, acc}, 128'd1);
        step(1'b1, 128'd1,          128'd1, 1'b1, acc, ov); check_eq("t1_acc1", {127'd0, acc}, 128'd1);
        step(1'b1, Q_W,             128'd0, 1'b1, acc, ov); check_eq("t1_acc2", {127'd0, acc}, 128'd1);
        step(1'b1, Q_W + 128'd5,    128'd5, 1'b1, acc, ov); check_eq("t1_acc3", {127'd0, acc}, 128'd1);
        drain("t1_drain");

        // Boundary products
        step(1'b1, (Q_W - 128'd1) * (Q_W - 128'd1), 128'd1, 1'b1, acc, ov);
        step(1'b1, 128'd1 << 64, 128'hFFFF_FFFF, 1'b1, acc, ov);
        step(1'b1, 128'd1 << 96, Q_W - 128'd1, 1'b1, acc, ov);
        step(1'b1, Q_W * Q_W - 128'd1, Q_W - 128'd1, 1'b1, acc, ov);
        drain("t2_drain");
        chk_lat = 1'b0;

        // Back-pressure: only three items fit before in_ready drops
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            a = 128'(k) * 128'h1234_5678_9ABC_DEF0_1357 + 128'd77;
            step(1'b1, a, ref_mod(a), 1'b0, acc, ov);
            if (acc) n_acc++;
        end
        check_eq("stall_accepted", 128'(n_acc), 128'd3);
        check_eq("stall_out_valid", {127'd0, out_valid}, 128'd1);
        snap_r = out_r;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 128'd9, 128'd9, 1'b0, acc, ov);
            check_eq("stall_in_ready", {127'd0, acc}, 128'd0);
            check_eq("stall_hold_valid", {127'd0, out_valid}, 128'd1);
            check_eq("stall_hold_r", {64'd0, out_r}, {64'd0, snap_r});
        end
        drain("t3_drain");

        // Bubble pattern 1,0,1,1,0 reappears three cycles later
        chk_lat = 1'b1;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            a = 128'(i) * 128'hDEAD_BEEF_0000_0001_2345;
            step((i < 5) ? pat[i] : 1'b0, a, ref_mod(a), 1'b1, acc, ov);
            ov_log[i] = ov;
        end
        for (int i = 0; i < 5; i++) check_eq($sformatf("bubble_%0d", i), {127'd0, ov_log[i+3]}, {127'd0, pat[i]});
        chk_lat = 1'b0;
        drain("t4_drain");

        // Asynchronous reset with items in flight
        for (int k = 0; k < 3; k++) step(1'b1, 128'd1000 + 128'(k), 128'd1000 + 128'(k), 1'b0, acc, ov);
        rst = 1'b0;
        #1;
        check_eq("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check_eq("midrst_out_r", {64'd0, out_r}, 128'd0);
        exp_q.delete();
        cyc_q.delete();
        tag_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        any_ov = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, '0, '0, 1'b1, acc, ov);
            any_ov |= ov;
        end
        check_eq("midrst_no_stale", {127'd0, any_ov}, 128'd0);

        // Random products with random back-pressure
        for (int k = 0; k < 4000; k++) begin
            a = rand_res();
            b = rand_res();
            p = a * b;
            step(($urandom % 4) != 0, p, ref_mod(p), ($urandom % 3) != 0, acc, ov);
        end
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
